// File: rtl/uart_menu_ctrl.sv
// Single-character menu front end for the rs232_uart FIFOs: pops one rx byte per command,
// pulses the audio engine and streams an ASCII reply. Define UART_MENU_ECHO_EN to echo each byte + CR/LF first.
module uart_menu_ctrl #(
  parameter int NUM_MSGS = 4,
  parameter int SEL_W    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data_in,
  input  logic             rx_data_present,
  output logic             read_rx_data_ack,
  output logic [7:0]       tx_data_out,
  output logic             write_tx_data,
  input  logic             tx_buffer_full,
  input  logic             engine_busy,
  output logic             cmd_record,
  output logic             cmd_play,
  output logic             cmd_stop,
  output logic [SEL_W-1:0] msg_sel,
  output logic             menu_busy
);

  typedef enum logic [2:0] {S_IDLE, S_POP, S_DECODE, S_SEND, S_GAP} state_e;
  typedef enum logic [1:0] {STR_OK, STR_BSY, STR_UNK} str_id_e;

  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] NUL      = 8'h00;
  localparam logic [7:0] DIGIT_LO = 8'h30;
  localparam logic [7:0] DIGIT_HI = 8'(8'h30 + NUM_MSGS);

`ifdef UART_MENU_ECHO_EN
  localparam int PRE_LEN = 3;
`else
  localparam int PRE_LEN = 0;
`endif

  // Row = string id, column = char index; the spare fourth row keeps every 2-bit id in range.
  localparam logic [0:3][0:4][7:0] STR_TABLE = {
    "O", "K", CR,  LF,  NUL,
    "B", "S", "Y", CR,  LF,
    "?", CR,  LF,  NUL, NUL,
    "?", CR,  LF,  NUL, NUL
  };

  function automatic logic [2:0] last_idx(input str_id_e id);
    case (id)
      STR_OK:  return 3'(PRE_LEN + 3);
      STR_BSY: return 3'(PRE_LEN + 4);
      default: return 3'(PRE_LEN + 2);
    endcase
  endfunction

  state_e           state_q,    state_d;
  str_id_e          str_id_q,   str_id_d;
  logic [7:0]       cmd_byte_q, cmd_byte_d;
  logic [2:0]       idx_q,      idx_d;
  logic             ack_q,      ack_d;
  logic [7:0]       tx_data_q,  tx_data_d;
  logic             write_q,    write_d;
  logic             record_q,   record_d;
  logic             play_q,     play_d;
  logic             stop_q,     stop_d;
  logic [SEL_W-1:0] msg_sel_q,  msg_sel_d;
  logic             busy_q,     busy_d;

  logic [2:0] resp_idx;
  logic [7:0] send_char;

  always_comb begin
    resp_idx  = idx_q - 3'(PRE_LEN);
    send_char = STR_TABLE[str_id_q][resp_idx];
`ifdef UART_MENU_ECHO_EN
    if (idx_q == 3'd0)      send_char = cmd_byte_q;
    else if (idx_q == 3'd1) send_char = CR;
    else if (idx_q == 3'd2) send_char = LF;
`endif
  end

  // NOTE: every _d signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    str_id_d   = str_id_q;
    cmd_byte_d = cmd_byte_q;
    idx_d      = idx_q;
    ack_d      = 1'b0;
    tx_data_d  = tx_data_q;
    write_d    = 1'b0;
    record_d   = 1'b0;
    play_d     = 1'b0;
    stop_d     = 1'b0;
    msg_sel_d  = msg_sel_q;

    case (state_q)
      S_IDLE: begin
        if (rx_data_present) begin
          state_d = S_POP;
          ack_d   = 1'b1;
        end
      end
      S_POP: begin
        cmd_byte_d = rx_data_in;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        state_d  = S_SEND;
        idx_d    = '0;
        str_id_d = STR_UNK;
        if (cmd_byte_q == "R" || cmd_byte_q == "r") begin
          record_d = !engine_busy;
          str_id_d = engine_busy ? STR_BSY : STR_OK;
        end else if (cmd_byte_q == "P" || cmd_byte_q == "p") begin
          play_d   = !engine_busy;
          str_id_d = engine_busy ? STR_BSY : STR_OK;
        end else if (cmd_byte_q == "S" || cmd_byte_q == "s") begin
          stop_d   = 1'b1;
          str_id_d = STR_OK;
        end else if (cmd_byte_q >= DIGIT_LO && cmd_byte_q < DIGIT_HI) begin
          msg_sel_d = SEL_W'(cmd_byte_q - DIGIT_LO);
          str_id_d  = STR_OK;
        end
      end
      S_SEND: begin
        if (!tx_buffer_full) begin
          tx_data_d = send_char;
          write_d   = 1'b1;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        // The gap cycle lets tx_buffer_full reflect the write before SEND samples it again.
        if (idx_q == last_idx(str_id_q)) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      str_id_q   <= STR_OK;
      cmd_byte_q <= '0;
      idx_q      <= '0;
      ack_q      <= 1'b0;
      tx_data_q  <= '0;
      write_q    <= 1'b0;
      record_q   <= 1'b0;
      play_q     <= 1'b0;
      stop_q     <= 1'b0;
      msg_sel_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      str_id_q   <= str_id_d;
      cmd_byte_q <= cmd_byte_d;
      idx_q      <= idx_d;
      ack_q      <= ack_d;
      tx_data_q  <= tx_data_d;
      write_q    <= write_d;
      record_q   <= record_d;
      play_q     <= play_d;
      stop_q     <= stop_d;
      msg_sel_q  <= msg_sel_d;
      busy_q     <= busy_d;
    end
  end

  assign read_rx_data_ack = ack_q;
  assign tx_data_out      = tx_data_q;
  assign write_tx_data    = write_q;
  assign cmd_record       = record_q;
  assign cmd_play         = play_q;
  assign cmd_stop         = stop_q;
  assign msg_sel          = msg_sel_q;
  assign menu_busy        = busy_q;

endmodule

// File: tb/tb_uart_menu_ctrl.sv
// Self-checking bench for uart_menu_ctrl: rx FIFO model, tx byte scoreboard and a command vector table.
module tb_uart_menu_ctrl;

  localparam int NUM_MSGS = 4;
  localparam int SEL_W    = 2;
`ifdef UART_MENU_ECHO_EN
  localparam int ECHO_LEN = 3;
`else
  localparam int ECHO_LEN = 0;
`endif
  localparam logic [1:0] SID_OK  = 2'd0;
  localparam logic [1:0] SID_BSY = 2'd1;
  localparam logic [1:0] SID_UNK = 2'd2;

  logic             clk             = 1'b0;
  logic             reset           = 1'b1;
  logic [7:0]       rx_data_in      = 8'h00;
  logic             rx_data_present = 1'b0;
  logic             tx_buffer_full  = 1'b0;
  logic             engine_busy     = 1'b0;
  logic             read_rx_data_ack;
  logic [7:0]       tx_data_out;
  logic             write_tx_data;
  logic             cmd_record, cmd_play, cmd_stop;
  logic [SEL_W-1:0] msg_sel;
  logic             menu_busy;

  always #5 clk = ~clk;

  uart_menu_ctrl #(.NUM_MSGS(NUM_MSGS), .SEL_W(SEL_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data_in       (rx_data_in),
    .rx_data_present  (rx_data_present),
    .read_rx_data_ack (read_rx_data_ack),
    .tx_data_out      (tx_data_out),
    .write_tx_data    (write_tx_data),
    .tx_buffer_full   (tx_buffer_full),
    .engine_busy      (engine_busy),
    .cmd_record       (cmd_record),
    .cmd_play         (cmd_play),
    .cmd_stop         (cmd_stop),
    .msg_sel          (msg_sel),
    .menu_busy        (menu_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // rx FIFO model: pops on the ack edge, head/present update after the edge.
  logic [7:0] rx_q[$];
  always @(posedge clk) begin
    if (read_rx_data_ack && rx_q.size() != 0) void'(rx_q.pop_front());
    rx_data_present <= (rx_q.size() != 0);
    rx_data_in      <= (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  end

  // Scoreboard of expected tx bytes.
  logic [7:0] exp_q[$];

  function automatic int reply_len(input logic [1:0] sid);
    if (sid == SID_OK)  return ECHO_LEN + 4;
    if (sid == SID_BSY) return ECHO_LEN + 5;
    return ECHO_LEN + 3;
  endfunction

  task automatic send_cmd(input logic [7:0] cmd, input logic [1:0] sid);
    if (ECHO_LEN != 0) begin
      exp_q.push_back(cmd);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    if (sid == SID_OK) begin
      exp_q.push_back(8'h4F); exp_q.push_back(8'h4B);
    end else if (sid == SID_BSY) begin
      exp_q.push_back(8'h42); exp_q.push_back(8'h53); exp_q.push_back(8'h59);
    end else begin
      exp_q.push_back(8'h3F);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    rx_q.push_back(cmd);
  endtask

  // Monitor, sampled 1 time unit after each rising edge.
  int   cyc = 0, n_ack = 0, n_rec = 0, n_play = 0, n_stop = 0, n_wr = 0;
  int   last_ack_cyc = -100, last_wr_cyc = -100;
  int   wr_at_ack[$];
  logic prev_ack = 1'b0;

  always @(posedge clk) begin
    logic [7:0] exp_b;
    cyc++;
    #1;
    if (!reset) begin
      if (read_rx_data_ack) begin
        check("ack_single_cycle", 32'(prev_ack), 32'd0);
        n_ack++;
        last_ack_cyc = cyc;
        wr_at_ack.push_back(n_wr);
      end
      if (cmd_record || cmd_play || cmd_stop) begin
        check("cmd_pulse_latency", 32'(cyc - last_ack_cyc), 32'd2);
        check("cmd_onehot", 32'(cmd_record) + 32'(cmd_play) + 32'(cmd_stop), 32'd1);
      end
      n_rec  += int'(cmd_record);
      n_play += int'(cmd_play);
      n_stop += int'(cmd_stop);
      if (write_tx_data) begin
        check("write_while_full", 32'(tx_buffer_full), 32'd0);
        check("write_spacing_ge2", 32'((cyc - last_wr_cyc) >= 2), 32'd1);
        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_b = exp_q.pop_front();
          check("tx_byte", 32'(tx_data_out), 32'(exp_b));
        end
        n_wr++;
        last_wr_cyc = cyc;
      end
    end
    prev_ack = read_rx_data_ack;
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((rx_q.size() != 0 || exp_q.size() != 0 || menu_busy || rx_data_present) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", 32'(n < budget), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"},     32'(read_rx_data_ack), 32'd0);
    check({tag, "_write"},   32'(write_tx_data),    32'd0);
    check({tag, "_tx_data"}, 32'(tx_data_out),      32'd0);
    check({tag, "_cmds"},    {29'd0, cmd_record, cmd_play, cmd_stop}, 32'd0);
    check({tag, "_msg_sel"}, 32'(msg_sel),          32'd0);
    check({tag, "_busy"},    32'(menu_busy),        32'd0);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic       busy;
    logic [1:0] sid;
    int         rec;
    int         play;
    int         stop;
    int         sel;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  initial begin
    int b_ack, b_rec, b_play, b_stop, b_wr, n;

    vecs[0]  = '{8'h72, 1'b0, SID_OK,  1, 0, 0, 0};  // 'r' idle engine
    vecs[1]  = '{8'h50, 1'b1, SID_BSY, 0, 0, 0, 0};  // 'P' busy engine
    vecs[2]  = '{8'h32, 1'b0, SID_OK,  0, 0, 0, 2};  // '2'
    vecs[3]  = '{8'h37, 1'b0, SID_UNK, 0, 0, 0, 2};  // '7' out of range
    vecs[4]  = '{8'h53, 1'b1, SID_OK,  0, 0, 1, 2};  // 'S' ignores busy
    vecs[5]  = '{8'h70, 1'b0, SID_OK,  0, 1, 0, 2};  // 'p'
    vecs[6]  = '{8'h52, 1'b1, SID_BSY, 0, 0, 0, 2};  // 'R' busy engine
    vecs[7]  = '{8'h33, 1'b0, SID_OK,  0, 0, 0, 3};  // '3' top slot
    vecs[8]  = '{8'h34, 1'b0, SID_UNK, 0, 0, 0, 3};  // '4' first out-of-range digit
    vecs[9]  = '{8'h0D, 1'b0, SID_UNK, 0, 0, 0, 3};  // CR
    vecs[10] = '{8'h30, 1'b0, SID_OK,  0, 0, 0, 0};  // '0'
    vecs[11] = '{8'h31, 1'b0, SID_OK,  0, 0, 0, 1};  // '1'
    vecs[12] = '{8'h78, 1'b0, SID_UNK, 0, 0, 0, 1};  // 'x'
    vecs[13] = '{8'h2F, 1'b0, SID_UNK, 0, 0, 0, 1};  // '/' just below '0'

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      engine_busy = vecs[i].busy;
      b_ack = n_ack; b_rec = n_rec; b_play = n_play; b_stop = n_stop; b_wr = n_wr;
      send_cmd(vecs[i].cmd, vecs[i].sid);
      wait_idle(300);
      check($sformatf("v%0d_acks", i),    32'(n_ack - b_ack),   32'd1);
      check($sformatf("v%0d_record", i),  32'(n_rec - b_rec),   32'(vecs[i].rec));
      check($sformatf("v%0d_play", i),    32'(n_play - b_play), 32'(vecs[i].play));
      check($sformatf("v%0d_stop", i),    32'(n_stop - b_stop), 32'(vecs[i].stop));
      check($sformatf("v%0d_writes", i),  32'(n_wr - b_wr),     32'(reply_len(vecs[i].sid)));
      check($sformatf("v%0d_msg_sel", i), 32'(msg_sel),         32'(vecs[i].sel));
    end
    engine_busy = 1'b0;

    // Back-pressure: hold the tx FIFO full right after the first write of the 'S' reply.
    b_stop = n_stop; b_wr = n_wr;
    send_cmd(8'h53, SID_OK);
    n = 0;
    while (n_wr == b_wr && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_first_write_seen", 32'(n_wr - b_wr), 32'd1);
    tx_buffer_full = 1'b1;
    repeat (50) @(negedge clk);
    check("bp_no_write_while_full", 32'(n_wr - b_wr), 32'd1);
    check("bp_still_busy", 32'(menu_busy), 32'd1);
    tx_buffer_full = 1'b0;
    wait_idle(300);
    check("bp_writes_total", 32'(n_wr - b_wr), 32'(reply_len(SID_OK)));
    check("bp_stop_once", 32'(n_stop - b_stop), 32'd1);
    check("bp_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Two commands already queued: second pop only after the first reply is fully written.
    b_ack = n_ack; b_stop = n_stop; b_wr = n_wr;
    wr_at_ack.delete();
    send_cmd(8'h53, SID_OK);
    send_cmd(8'h73, SID_OK);
    wait_idle(600);
    check("b2b_acks", 32'(n_ack - b_ack), 32'd2);
    check("b2b_stops", 32'(n_stop - b_stop), 32'd2);
    check("b2b_writes", 32'(n_wr - b_wr), 32'(2 * reply_len(SID_OK)));
    check("b2b_ack_records", 32'(wr_at_ack.size()), 32'd2);
    if (wr_at_ack.size() >= 2)
      check("b2b_second_ack_after_reply", 32'(wr_at_ack[1] - b_wr), 32'(reply_len(SID_OK)));

    // Reset in the middle of a reply: everything clears and no further bytes go out.
    b_wr = n_wr;
    send_cmd(8'h53, SID_OK);
    n = 0;
    while (n_wr - b_wr < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_two_writes_before_reset", 32'(n_wr - b_wr), 32'd2);
    reset = 1'b1;
    #1;
    check_outputs_zero("rst_mid_send");
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    b_wr = n_wr;
    repeat (20) @(negedge clk);
    check("rst_no_writes_after_release", 32'(n_wr - b_wr), 32'd0);
    check("rst_idle_after_release", 32'(menu_busy), 32'd0);
    check("rst_msg_sel_cleared", 32'(msg_sel), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
